// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: op codes, alu_op encodings, funct values, class helpers.
// Latency: none, constants and pure functions only.
// Backpressure: not applicable.
package alu_ctrl_pkg;

   typedef logic [3:0] opc_t;

   // 4-bit ALU operation codes
   localparam opc_t OP_AND   = 4'b0000;
   localparam opc_t OP_OR    = 4'b0001;
   localparam opc_t OP_ADD   = 4'b0010;
   localparam opc_t OP_XOR   = 4'b0011;
   localparam opc_t OP_MFHI  = 4'b0100;
   localparam opc_t OP_MFLO  = 4'b0101;
   localparam opc_t OP_SUB   = 4'b0110;
   localparam opc_t OP_SLT   = 4'b0111;
   localparam opc_t OP_SRL   = 4'b1000;
   localparam opc_t OP_SRA   = 4'b1001;
   localparam opc_t OP_MULT  = 4'b1010;
   localparam opc_t OP_MULTU = 4'b1011;
   localparam opc_t OP_NOR   = 4'b1100;
   localparam opc_t OP_DIV   = 4'b1101;
   localparam opc_t OP_SLL   = 4'b1110;
   localparam opc_t OP_DIVU  = 4'b1111;

   // alu_op encodings coming from the main decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_RSVD  = 2'b11;

   // R-type funct field values
   localparam logic [5:0] FN_SLL   = 6'd0;
   localparam logic [5:0] FN_SRL   = 6'd2;
   localparam logic [5:0] FN_SRA   = 6'd3;
   localparam logic [5:0] FN_MFHI  = 6'd16;
   localparam logic [5:0] FN_MFLO  = 6'd18;
   localparam logic [5:0] FN_MULT  = 6'd24;
   localparam logic [5:0] FN_MULTU = 6'd25;
   localparam logic [5:0] FN_DIV   = 6'd26;
   localparam logic [5:0] FN_DIVU  = 6'd27;
   localparam logic [5:0] FN_ADD   = 6'd32;
   localparam logic [5:0] FN_SUB   = 6'd34;
   localparam logic [5:0] FN_AND   = 6'd36;
   localparam logic [5:0] FN_OR    = 6'd37;
   localparam logic [5:0] FN_XOR   = 6'd38;
   localparam logic [5:0] FN_NOR   = 6'd39;
   localparam logic [5:0] FN_SLT   = 6'd42;

   // Ops that occupy the mult/div unit
   function automatic logic is_muldiv(input opc_t op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // Ops that read HI/LO and so must wait for the unit to finish
   function automatic logic is_hilo(input opc_t op);
      return (op == OP_MFHI) || (op == OP_MFLO);
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational alu_op/funct decode to ALU op code plus illegal and unit-class flags.
// Latency: zero, purely combinational.
// Backpressure: none; the caller gates acceptance.
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [3:0] op,
   output logic       illegal,
   output logic       is_muldiv,
   output logic       is_hilo,
   output logic       is_div
);

   // Map the request to an op code; anything undecodable becomes ADD with illegal set
   always_comb begin
      op      = OP_ADD;
      illegal = 1'b0;
      case (alu_op)
         ALUOP_ADD: op = OP_ADD;
         ALUOP_SUB: op = OP_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_SLL:   op = OP_SLL;
               FN_SRL:   op = OP_SRL;
               FN_SRA:   op = OP_SRA;
               FN_MFHI:  op = OP_MFHI;
               FN_MFLO:  op = OP_MFLO;
               FN_MULT:  op = OP_MULT;
               FN_MULTU: op = OP_MULTU;
               FN_DIV:   op = OP_DIV;
               FN_DIVU:  op = OP_DIVU;
               FN_ADD:   op = OP_ADD;
               FN_SUB:   op = OP_SUB;
               FN_AND:   op = OP_AND;
               FN_OR:    op = OP_OR;
               FN_XOR:   op = OP_XOR;
               FN_NOR:   op = OP_NOR;
               FN_SLT:   op = OP_SLT;
               default:  illegal = 1'b1;
            endcase
         end
         ALUOP_RSVD: illegal = 1'b1;
         default:    illegal = 1'b1;
      endcase
   end

   // Illegal requests decode to ADD, so these flags are never set for them
   assign is_muldiv = alu_ctrl_pkg::is_muldiv(op);
   assign is_hilo   = alu_ctrl_pkg::is_hilo(op);
   assign is_div    = (op == OP_DIV) || (op == OP_DIVU);

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control decode with mult/div occupancy counter and HI/LO hazard gating.
// Latency: accept at edge N drives op/illegal from N+1; 1 request/cycle when out_ready stays high.
// Backpressure: in_ready low while output stalls (no skid) or while a unit/HI-LO op meets a busy unit.
module alu_ctrl_pipe
   import alu_ctrl_pkg::*;
#(
   parameter int MULT_LAT = 4,
   parameter int DIV_LAT  = 32,
   parameter int CNT_W    = $clog2(DIV_LAT + 1)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] op,
   output logic       illegal,
   output logic       md_start,
   output logic       md_busy
);

   logic [3:0]       dec_op;
   logic             dec_illegal;
   logic             dec_muldiv;
   logic             dec_hilo;
   logic             dec_div;
   logic [CNT_W-1:0] cnt;
   logic             block;
   logic             accept;

   alu_ctrl_decode u_decode (
      .alu_op    (alu_op),
      .funct     (funct),
      .op        (dec_op),
      .illegal   (dec_illegal),
      .is_muldiv (dec_muldiv),
      .is_hilo   (dec_hilo),
      .is_div    (dec_div)
   );

   // Hazard gate looks only at the current count, never at what is being accepted now
   assign md_busy  = (cnt != '0);
   assign block    = md_busy && (dec_muldiv || dec_hilo);
   assign in_ready = (!out_valid || out_ready) && !block;
   assign accept   = in_valid && in_ready;

   // Output register: load on accept, hold while stalled, drop valid once consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         op        <= OP_AND;
         illegal   <= 1'b0;
         md_start  <= 1'b0;
      end else begin
         md_start <= accept && dec_muldiv;
         if (accept) begin
            out_valid <= 1'b1;
            op        <= dec_op;
            illegal   <= dec_illegal;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Busy counter: a new mult/div load wins over the decrement; decrements even when output is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (accept && dec_muldiv) begin
         cnt <= dec_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: directed scenarios plus randomized traffic against a reference model.
// Latency: model tracks one-cycle output register and unit free time as an absolute edge number.
// Backpressure: upstream holds a request until accepted; out_ready is randomized.
module tb_alu_ctrl_pipe;

   localparam int MULT_LAT = 4;
   localparam int DIV_LAT  = 32;
   localparam int CNT_W    = $clog2(DIV_LAT + 1);

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] alu_op;
   logic [5:0] funct;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] op;
   logic       illegal;
   logic       md_start;
   logic       md_busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference decode table: op code per funct, -1 for undecodable
   int fn_op [64];

   // Reference state: output register contents and the edge at which the unit becomes free
   int         edge_cnt;
   int         free_edge;
   logic       m_ov;
   logic [3:0] m_op;
   logic       m_ill;
   logic       m_start;

   always #5 clk = ~clk;

   alu_ctrl_pipe #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT),
      .CNT_W    (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .funct     (funct),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .op        (op),
      .illegal   (illegal),
      .md_start  (md_start),
      .md_busy   (md_busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void ref_dec(input logic [1:0] a, input logic [5:0] f,
                                   output logic [3:0] o, output logic ill,
                                   output int lat, output logic unit);
      o    = 4'b0010;
      ill  = 1'b0;
      lat  = 0;
      unit = 1'b0;
      if (a == 2'b01) begin
         o = 4'b0110;
      end else if (a == 2'b11) begin
         ill = 1'b1;
      end else if (a == 2'b10) begin
         if (fn_op[f] < 0) ill = 1'b1;
         else              o   = 4'(fn_op[f]);
         if (f == 6'd24 || f == 6'd25) lat = MULT_LAT;
         if (f == 6'd26 || f == 6'd27) lat = DIV_LAT;
         unit = (lat != 0) || (f == 6'd16) || (f == 6'd18);
      end
   endfunction

   function automatic int m_cnt();
      return (free_edge > edge_cnt) ? (free_edge - edge_cnt) : 0;
   endfunction

   task automatic model_reset();
      edge_cnt  = 0;
      free_edge = 0;
      m_ov      = 1'b0;
      m_op      = 4'b0000;
      m_ill     = 1'b0;
      m_start   = 1'b0;
   endtask

   // One clock: drive inputs after a falling edge, check in_ready, step the model, check outputs
   task automatic cycle(input logic v, input logic [1:0] a, input logic [5:0] f,
                        input logic r, output logic acc);
      logic [3:0] o;
      logic       ill;
      logic       unit;
      logic       exp_rdy;
      int         lat;
      in_valid  = v;
      alu_op    = a;
      funct     = f;
      out_ready = r;
      #1;
      ref_dec(a, f, o, ill, lat, unit);
      exp_rdy = (!m_ov || r) && !(unit && (m_cnt() != 0));
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      acc = v && exp_rdy;
      @(posedge clk);
      edge_cnt++;
      m_start = 1'b0;
      if (acc) begin
         m_ov  = 1'b1;
         m_op  = o;
         m_ill = ill;
         if (lat != 0) begin
            m_start   = 1'b1;
            free_edge = edge_cnt + lat;
         end
      end else if (r) begin
         m_ov = 1'b0;
      end
      @(negedge clk);
      check("out_valid", 32'(out_valid), 32'(m_ov));
      check("op",        32'(op),        32'(m_op));
      check("illegal",   32'(illegal),   32'(m_ill));
      check("md_start",  32'(md_start),  32'(m_start));
      check("md_busy",   32'(md_busy),   32'(m_cnt() != 0));
      check("cnt",       32'(dut.cnt),   32'(m_cnt()));
   endtask

   // Present one request until accepted (bounded); returns the accepting edge number or -1
   task automatic send(input logic [1:0] a, input logic [5:0] f, input int bound,
                       output int acc_edge);
      logic acc;
      acc      = 1'b0;
      acc_edge = -1;
      for (int i = 0; i < bound; i++) begin
         cycle(1'b1, a, f, 1'b1, acc);
         if (acc) begin
            acc_edge = edge_cnt;
            break;
         end
      end
      check("send_accepted", 32'(acc), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic idle_until_free();
      logic acc;
      for (int i = 0; i < 64; i++) begin
         if (m_cnt() == 0 && !m_ov) break;
         cycle(1'b0, 2'b00, 6'd0, 1'b1, acc);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         seq_f [8];
      int         seq_o [8];
      int         legal_f [16];
      int         e0, e1, e2, e3, busy_n;
      logic       acc, pending, v, r;
      logic [1:0] a;
      logic [5:0] f;

      foreach (fn_op[i]) fn_op[i] = -1;
      fn_op[0]  = 14; fn_op[2]  = 8;  fn_op[3]  = 9;  fn_op[16] = 4;
      fn_op[18] = 5;  fn_op[24] = 10; fn_op[25] = 11; fn_op[26] = 13;
      fn_op[27] = 15; fn_op[32] = 2;  fn_op[34] = 6;  fn_op[36] = 0;
      fn_op[37] = 1;  fn_op[38] = 3;  fn_op[39] = 12; fn_op[42] = 7;

      seq_f   = '{36, 37, 38, 39, 42, 0, 2, 3};
      seq_o   = '{0, 1, 3, 12, 7, 14, 8, 9};
      legal_f = '{0, 2, 3, 16, 18, 24, 25, 26, 27, 32, 34, 36, 37, 38, 39, 42};

      // Reset state
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      alu_op    = 2'b00;
      funct     = 6'd0;
      out_ready = 1'b1;
      model_reset();
      #13;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_op",        32'(op),        32'd0);
      check("rst_illegal",   32'(illegal),   32'd0);
      check("rst_md_start",  32'(md_start),  32'd0);
      check("rst_md_busy",   32'(md_busy),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Back-to-back logic/shift ops at full throughput
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 2'b10, 6'(seq_f[i]), 1'b1, acc);
         check("seq_acc", 32'(acc), 32'd1);
         check("seq_op",  32'(op),  32'(seq_o[i]));
         check("seq_ill", 32'(illegal), 32'd0);
      end
      cycle(1'b0, 2'b00, 6'd0, 1'b1, acc);

      // Reserved alu_op and unknown funct
      cycle(1'b1, 2'b11, 6'd0, 1'b1, acc);
      check("rsvd_op",   32'(op),      32'd2);
      check("rsvd_ill",  32'(illegal), 32'd1);
      check("rsvd_busy", 32'(md_busy), 32'd0);
      cycle(1'b1, 2'b10, 6'd5, 1'b1, acc);
      check("fn5_op",    32'(op),       32'd2);
      check("fn5_ill",   32'(illegal),  32'd1);
      check("fn5_start", 32'(md_start), 32'd0);
      check("fn5_busy",  32'(md_busy),  32'd0);
      cycle(1'b0, 2'b00, 6'd0, 1'b1, acc);

      // MULT then MFLO waits out the multiply latency
      send(2'b10, 6'd24, 4, e0);
      check("mult_start", 32'(md_start), 32'd1);
      busy_n = md_busy ? 1 : 0;
      e1 = -1;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 2'b10, 6'd18, 1'b1, acc);
         if (acc) begin
            e1 = edge_cnt;
            break;
         end
         if (md_busy) busy_n++;
      end
      in_valid = 1'b0;
      check("mflo_edge",   32'(e1 - e0), 32'(MULT_LAT + 1));
      check("mflo_op",     32'(op),      32'd5);
      check("mult_busy_n", 32'(busy_n),  32'(MULT_LAT));
      idle_until_free();

      // DIV, then ADD/SUB pass freely, MULT waits for the divider
      send(2'b10, 6'd26, 4, e0);
      send(2'b00, 6'd0, 1, e1);
      send(2'b01, 6'd0, 1, e2);
      check("add_pass", 32'(e1 - e0), 32'd1);
      check("sub_pass", 32'(e2 - e0), 32'd2);
      send(2'b10, 6'd24, 60, e3);
      check("mult_after_div_edge", 32'(e3 - e0), 32'(DIV_LAT + 1));
      check("mult_after_div_op",   32'(op),      32'd10);
      check("mult_reload_cnt",     32'(dut.cnt), 32'(MULT_LAT));
      idle_until_free();

      // DIVU with output stalled for three cycles
      send(2'b10, 6'd27, 4, e0);
      check("divu_start", 32'(md_start), 32'd1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 2'b00, 6'd0, 1'b0, acc);
         check("divu_hold_op",    32'(op),        32'd15);
         check("divu_hold_vld",   32'(out_valid), 32'd1);
         check("divu_hold_start", 32'(md_start),  32'd0);
      end
      check("divu_cnt_release", 32'(dut.cnt), 32'(DIV_LAT - 3));
      cycle(1'b0, 2'b00, 6'd0, 1'b1, acc);
      idle_until_free();

      // Asynchronous reset in the middle of a divide
      send(2'b10, 6'd26, 4, e0);
      for (int i = 0; i < 15; i++) cycle(1'b0, 2'b00, 6'd0, 1'b1, acc);
      check("div_cnt_mid", 32'(dut.cnt), 32'd17);
      rst_n = 1'b0;
      #1;
      check("arst_cnt",       32'(dut.cnt),   32'd0);
      check("arst_md_busy",   32'(md_busy),   32'd0);
      check("arst_out_valid", 32'(out_valid), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Randomized traffic with upstream hold and random output stalls
      pending = 1'b0;
      v = 1'b0;
      a = 2'b00;
      f = 6'd0;
      for (int n = 0; n < 3000; n++) begin
         if (!pending) begin
            v = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            f = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'(legal_f[$urandom_range(0, 15)]);
         end
         r = ($urandom_range(0, 3) != 0);
         cycle(v, a, f, r, acc);
         pending = v && !acc;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
